// File: rtl/psum_buf_pkg.sv
// Shared accelerator definitions: default psum width and the psum buffer state encoding.
package psum_buf_pkg;

    localparam int PSUM_WIDTH = 25;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/psum_buf_ram.sv
// Simple dual-port psum storage: one synchronous write port and one registered read port.
module psum_ram #(
    parameter int data_width = 25,
    parameter int depth      = 256,
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [addr_width-1:0] waddr_i,
    input  logic [data_width-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [addr_width-1:0] raddr_i,
    output logic [data_width-1:0] rdata_o
);

    logic [data_width-1:0] mem_q [depth];
    logic [data_width-1:0] rdata_q;

    // Read port holds its word until the next enabled read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/psum_buf.sv
// Partial-sum buffer: recirculates psums through the adder tree for cfg_passes passes
// and routes the last pass to out_data.
module psum_buf
    import psum_buf_pkg::*;
#(
    parameter int data_width = PSUM_WIDTH,
    parameter int depth      = 256,
    parameter int addr_width = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [addr_width:0]          cfg_len,
    input  logic [7:0]                   cfg_passes,
    input  logic                         rd_en,
    output logic signed [data_width-1:0] fifo_data,
    input  logic                         in_valid,
    input  logic signed [data_width-1:0] in_data,
    output logic                         out_valid,
    output logic signed [data_width-1:0] out_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam logic [addr_width:0]   LEN_ONE   = {{addr_width{1'b0}}, 1'b1};
    localparam logic [addr_width-1:0] PTR_ONE   = {{(addr_width-1){1'b0}}, 1'b1};
    localparam logic [addr_width:0]   LEN_DEPTH = (addr_width+1)'(depth);

    state_e                       state_q, state_d;
    logic [addr_width:0]          len_q, len_m1, credit_q;
    logic [7:0]                   passes_q, rd_pass_q, wr_pass_q;
    logic [addr_width-1:0]        rd_ptr_q, wr_ptr_q;
    logic                         zero_sel_q, out_valid_q, done_q, err_q;
    logic signed [data_width-1:0] out_data_q;
    logic [data_width-1:0]        ram_rdata;
    logic run, start_ok, rd_ok, rd_mem, wr_ok, wr_final, wr_store, rd_wrap, wr_wrap, job_end;

    assign run      = (state_q == RUN);
    assign start_ok = start && !run;
    assign len_m1   = len_q - LEN_ONE;
    assign rd_wrap  = ({1'b0, rd_ptr_q} == len_m1);
    assign wr_wrap  = ({1'b0, wr_ptr_q} == len_m1);
    // Pass 0 reads need no credit: they return zero without touching memory.
    assign rd_ok    = rd_en && run && (rd_pass_q < passes_q)
                      && ((rd_pass_q == 8'd0) || (credit_q != '0));
    assign rd_mem   = rd_ok && (rd_pass_q != 8'd0);
    assign wr_ok    = in_valid && run && (wr_pass_q < passes_q);
    assign wr_final = (wr_pass_q == passes_q - 8'd1);
    assign wr_store = wr_ok && !wr_final;
    assign job_end  = wr_ok && wr_final && wr_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_ok) begin
            state_d = RUN;
        end else if (job_end) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= LEN_DEPTH;
            passes_q    <= 8'd1;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_pass_q   <= '0;
            wr_pass_q   <= '0;
            credit_q    <= '0;
            zero_sel_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (start_ok) begin
                len_q     <= (cfg_len == '0) ? LEN_DEPTH : cfg_len;
                passes_q  <= (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                rd_pass_q <= '0;
                wr_pass_q <= '0;
                credit_q  <= '0;
                err_q     <= 1'b0;
            end else begin
                if (rd_ok) begin
                    rd_ptr_q   <= rd_wrap ? '0 : rd_ptr_q + PTR_ONE;
                    rd_pass_q  <= rd_wrap ? rd_pass_q + 8'd1 : rd_pass_q;
                    zero_sel_q <= (rd_pass_q == 8'd0);
                end
                if (wr_ok) begin
                    wr_ptr_q  <= wr_wrap ? '0 : wr_ptr_q + PTR_ONE;
                    wr_pass_q <= wr_wrap ? wr_pass_q + 8'd1 : wr_pass_q;
                end
                if (wr_ok && wr_final) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= in_data;
                end
                done_q <= job_end;
                if (wr_store && !rd_mem) begin
                    credit_q <= credit_q + LEN_ONE;
                end else if (!wr_store && rd_mem) begin
                    credit_q <= credit_q - LEN_ONE;
                end
                if ((rd_en && !rd_ok) || (in_valid && !wr_ok)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    psum_ram #(
        .data_width(data_width),
        .depth     (depth),
        .addr_width(addr_width)
    ) u_ram (
        .clk    (clk),
        .we_i   (wr_store),
        .waddr_i(wr_ptr_q),
        .wdata_i(in_data),
        .re_i   (rd_mem),
        .raddr_i(rd_ptr_q),
        .rdata_o(ram_rdata)
    );

    assign fifo_data = zero_sel_q ? '0 : $signed(ram_rdata);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_psum_buf.sv
// Scoreboard bench for psum_buf: a pass-level psum model queues expected fifo/out values,
// an independent monitor compares them whenever the DUT presents data.
module tb_psum_buf;
    localparam int DW    = 25;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    typedef struct {
        logic signed [DW-1:0] d;
        bit                   last;
    } out_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic [AW:0]          cfg_len = '0;
    logic [7:0]           cfg_passes = '0;
    logic                 rd_en = 1'b0;
    logic signed [DW-1:0] fifo_data;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic                 rd_seen = 1'b0;
    logic signed [DW-1:0] fifo_q [$];
    out_t                 out_q [$];

    psum_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_passes(cfg_passes),
        .rd_en     (rd_en),
        .fifo_data (fifo_data),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: a read seen at the last rising edge, or out_valid, consumes one expectation.
    always @(posedge clk) rd_seen <= rd_en;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_seen) begin
                if (fifo_q.size() == 0) check("fifo_unexpected_read", 1, 0);
                else check("fifo_data", fifo_data, fifo_q.pop_front());
            end
            if (out_valid) begin
                if (out_q.size() == 0) begin
                    check("out_valid_unexpected", out_valid, 0);
                end else begin
                    out_t e;
                    e = out_q.pop_front();
                    $display("out data=%0d exp=%0d done=%0b", out_data, e.d, done);
                    check("out_data", out_data, e.d);
                    check("done_with_last_out", done, e.last);
                end
            end else if (done) begin
                check("done_without_out", done, 0);
            end
            if (done) done_cnt++;
        end
    end

    task automatic drive(input bit r, input bit w, input logic signed [DW-1:0] d);
        @(negedge clk);
        rd_en = r;
        in_valid = w;
        in_data = d;
    endtask

    task automatic do_start(input int len_cfg, input int pas_cfg);
        @(negedge clk);
        start = 1'b1; rd_en = 1'b0; in_valid = 1'b0;
        cfg_len = (AW+1)'(len_cfg);
        cfg_passes = 8'(pas_cfg);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared_by_start", err, 0);
    endtask

    function automatic logic signed [DW-1:0] delta(input int mode, input int p, input int i);
        int v;
        case (mode)
            1: v = 5;
            2: v = 10 * (i + 1);
            3: v = (p == 0) ? i : 0;
            default: v = int'($urandom_range(0, 2000)) - 1000;
        endcase
        return DW'(v);
    endfunction

    // Reference: entry i of pass p reads 0 on pass 0, else the psum written for i on pass p-1.
    task automatic run_job(input int len_cfg, input int pas_cfg, input int mode, input bit overlap);
        int L, P, total;
        logic signed [DW-1:0] m [DEPTH];
        logic signed [DW-1:0] prev_w;
        L = (len_cfg == 0) ? DEPTH : len_cfg;
        P = (pas_cfg == 0) ? 1 : pas_cfg;
        total = L * P;
        prev_w = '0;
        do_start(len_cfg, pas_cfg);
        for (int k = 0; k < total; k++) begin
            int p, i;
            logic signed [DW-1:0] rv, w;
            p = k / L;
            i = k % L;
            rv = (p == 0) ? '0 : m[i];
            w = rv + delta(mode, p, i);
            if (p < P - 1) m[i] = w;
            else out_q.push_back('{d: w, last: (k == total - 1)});
            if (overlap && L >= 2) begin
                drive(1, k > 0, prev_w);
                fifo_q.push_back(rv);
            end else begin
                drive(1, 0, '0);
                fifo_q.push_back(rv);
                repeat ($urandom_range(0, 1)) drive(0, 0, '0);
                drive(0, 1, w);
                repeat ($urandom_range(0, 1)) drive(0, 0, '0);
            end
            prev_w = w;
        end
        if (overlap && L >= 2) drive(0, 1, prev_w);
        exp_done++;
        drive(0, 0, '0);
        check("busy_after_done", busy, 0);
        drive(0, 0, '0);
    endtask

    initial begin
        logic signed [DW-1:0] a0, a1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_fifo_data", fifo_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk); rst_n = 1'b1;

        run_job(4, 1, 2, 1'b0);        // reads 0, outputs 10,20,30,40
        run_job(3, 3, 1, 1'b0);        // adder adds 5 per pass: outputs 15
        run_job(3, 3, 1, 1'b1);
        run_job(0, 2, 3, 1'b1);        // 256 entries, pass-1 reads 0..255

        // Read with no credit, then read after all passes: err, pointer and fifo_data hold.
        do_start(2, 2);
        a0 = DW'($urandom_range(1, 5000));
        a1 = DW'($urandom_range(1, 5000));
        drive(1, 0, '0); fifo_q.push_back('0);
        drive(1, 0, '0); fifo_q.push_back('0);
        drive(1, 0, '0); fifo_q.push_back('0);
        drive(0, 0, '0);
        check("err_no_credit", err, 1);
        drive(0, 1, a0);
        drive(0, 1, a1);
        drive(1, 0, '0); fifo_q.push_back(a0);
        drive(1, 0, '0); fifo_q.push_back(a1);
        drive(1, 0, '0); fifo_q.push_back(a1);
        drive(0, 1, a0 + 7); out_q.push_back('{d: a0 + 7, last: 1'b0});
        drive(0, 1, a1 + 7); out_q.push_back('{d: a1 + 7, last: 1'b1});
        exp_done++;
        drive(0, 0, '0);
        drive(0, 0, '0);
        check("err_sticky", err, 1);
        check("busy_idle_after_err_job", busy, 0);

        // Reset in the middle of pass 1 abandons the job.
        do_start(3, 2);
        drive(1, 0, '0); fifo_q.push_back('0); drive(0, 1, a0);
        drive(1, 0, '0); fifo_q.push_back('0); drive(0, 1, a1);
        drive(1, 0, '0); fifo_q.push_back('0); drive(0, 1, a0);
        drive(1, 0, '0); fifo_q.push_back(a0);
        drive(0, 0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_fifo_data", fifo_data, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        fifo_q.delete();
        out_q.delete();
        @(negedge clk); rst_n = 1'b1;
        run_job(2, 1, 0, 1'b0);
        check("err_after_reset_job", err, 0);

        // Start while busy is ignored; in_valid after done is an error with no output.
        do_start(2, 1);
        @(negedge clk); start = 1'b1; cfg_len = 9'd3; cfg_passes = 8'd2;
        @(negedge clk); start = 1'b0;
        drive(1, 0, '0); fifo_q.push_back('0);
        drive(0, 1, a0); out_q.push_back('{d: a0, last: 1'b0});
        drive(1, 0, '0); fifo_q.push_back('0);
        drive(0, 1, a1); out_q.push_back('{d: a1, last: 1'b1});
        exp_done++;
        drive(0, 0, '0);
        check("busy_after_ignored_start_job", busy, 0);
        drive(0, 1, DW'(123));
        drive(0, 0, '0);
        drive(0, 0, '0);
        check("err_valid_after_done", err, 1);

        // Randomised jobs, including cfg_passes=0 treated as a single pass.
        run_job(3, 0, 0, 1'b1);
        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(1, 8)), int'($urandom_range(1, 4)), 0, 1'($urandom_range(0, 1)));
        end

        repeat (3) drive(0, 0, '0);
        check("fifo_queue_drained", fifo_q.size(), 0);
        check("out_queue_drained", out_q.size(), 0);
        check("done_pulse_count", done_cnt, exp_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
